// File: rtl/rv32i_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_decode_stage
// Brief    : RV32I decode/issue stage with a single-entry output register.
//            Optional illegal-instruction halt when DECODE_ILLEGAL_TRAP_EN is defined.
// Revision : 1.0
// ============================================================================
module rv32i_decode_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_instr,
   input  logic [31:0] in_pc,
   input  logic        flush,
   output logic [4:0]  rs1_addr,
   output logic [4:0]  rs2_addr,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] src1,
   output logic [31:0] src2,
   output logic [31:0] imm_val,
   output logic [5:0]  alu_cntrl,
   output logic [3:0]  shift_amount,
   output logic [4:0]  rd_addr,
   output logic        rd_we,
   output logic [31:0] out_pc,
   output logic        illegal
);

   localparam logic [5:0] C_ALU_ILLEGAL = 6'h3F;
   localparam logic [6:0] C_OP_R        = 7'b0110011;
   localparam logic [6:0] C_OP_I        = 7'b0010011;
   localparam logic [6:0] C_OP_LUI      = 7'b0110111;
   localparam logic [6:0] C_OP_S        = 7'b0100011;
   localparam logic [6:0] C_OP_B        = 7'b1100011;
   localparam logic [6:0] C_F7_BASE     = 7'b0000000;
   localparam logic [6:0] C_F7_ALT      = 7'b0100000;

   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic [6:0]  w_funct7;
   logic [5:0]  w_alu_cntrl;
   logic [31:0] w_imm;
   logic        w_writes;
   logic        w_srai;
   logic        w_illegal;
   logic [31:0] w_src1;
   logic [31:0] w_src2;
   logic        w_rd_we;
   logic        w_run;
   logic        w_in_ready;
   logic        w_accept;

   logic        r_out_valid;
   logic [31:0] r_src1;
   logic [31:0] r_src2;
   logic [31:0] r_imm;
   logic [5:0]  r_alu_cntrl;
   logic [3:0]  r_shift_amount;
   logic [4:0]  r_rd_addr;
   logic        r_rd_we;
   logic [31:0] r_out_pc;
   logic        r_illegal;

   assign w_opcode = in_instr[6:0];
   assign w_funct3 = in_instr[14:12];
   assign w_funct7 = in_instr[31:25];
   assign rs1_addr = in_instr[19:15];
   assign rs2_addr = in_instr[24:20];

   // Anything that leaves alu_cntrl at the illegal code is treated as illegal.
   always_comb begin
      w_alu_cntrl = C_ALU_ILLEGAL;
      w_imm       = '0;
      w_writes    = 1'b0;
      w_srai      = 1'b0;
      case (w_opcode)
         C_OP_R: begin
            w_writes = 1'b1;
            if (w_funct7 == C_F7_BASE) begin
               case (w_funct3)
                  3'b000:  w_alu_cntrl = 6'h00;
                  3'b001:  w_alu_cntrl = 6'h02;
                  3'b010:  w_alu_cntrl = 6'h03;
                  3'b011:  w_alu_cntrl = 6'h04;
                  3'b100:  w_alu_cntrl = 6'h05;
                  3'b101:  w_alu_cntrl = 6'h06;
                  3'b110:  w_alu_cntrl = 6'h08;
                  default: w_alu_cntrl = 6'h09;
               endcase
            end else if (w_funct7 == C_F7_ALT) begin
               case (w_funct3)
                  3'b000:  w_alu_cntrl = 6'h01;
                  3'b101:  w_alu_cntrl = 6'h07;
                  default: ;
               endcase
            end
         end
         C_OP_I: begin
            w_writes = 1'b1;
            w_imm    = {{20{in_instr[31]}}, in_instr[31:20]};
            case (w_funct3)
               3'b000: w_alu_cntrl = 6'h0A;
               3'b001: if (w_funct7 == C_F7_BASE) w_alu_cntrl = 6'h0B;
               3'b010: w_alu_cntrl = 6'h0C;
               3'b011: w_alu_cntrl = 6'h0D;
               3'b100: w_alu_cntrl = 6'h0E;
               3'b101: begin
                  if (w_funct7 == C_F7_BASE) begin
                     w_alu_cntrl = 6'h0F;
                  end else if (w_funct7 == C_F7_ALT) begin
                     w_alu_cntrl = 6'h07;
                     w_srai      = 1'b1;
                  end
               end
               3'b110:  w_alu_cntrl = 6'h10;
               default: w_alu_cntrl = 6'h11;
            endcase
         end
         C_OP_LUI: begin
            w_writes    = 1'b1;
            w_alu_cntrl = 6'h12;
            w_imm       = {12'h000, in_instr[31:12]};
         end
         C_OP_S: begin
            w_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            case (w_funct3)
               3'b000:  w_alu_cntrl = 6'h17;
               3'b001:  w_alu_cntrl = 6'h18;
               3'b010:  w_alu_cntrl = 6'h19;
               default: ;
            endcase
         end
         C_OP_B: begin
            w_imm = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            case (w_funct3)
               3'b000:  w_alu_cntrl = 6'h1A;
               3'b001:  w_alu_cntrl = 6'h1B;
               3'b100:  w_alu_cntrl = 6'h1C;
               3'b101:  w_alu_cntrl = 6'h1D;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   assign w_illegal = (w_alu_cntrl == C_ALU_ILLEGAL);
   assign w_src1    = (rs1_addr == 5'd0) ? 32'd0 : rs1_data;
   assign w_src2    = w_srai ? {27'd0, in_instr[24:20]}
                    : ((rs2_addr == 5'd0) ? 32'd0 : rs2_data);
   assign w_rd_we   = w_writes & ~w_illegal & (in_instr[11:7] != 5'd0);

`ifdef DECODE_ILLEGAL_TRAP_EN
   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_RUN;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == ST_RUN && w_accept && w_illegal) w_state_nxt = ST_HALT;
   end

   assign w_run = (r_state == ST_RUN);
`else
   assign w_run = 1'b1;
`endif

   assign w_in_ready = (~r_out_valid | out_ready) & w_run;
   assign w_accept   = in_valid & w_in_ready & ~flush;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid    <= 1'b0;
         r_src1         <= '0;
         r_src2         <= '0;
         r_imm          <= '0;
         r_alu_cntrl    <= C_ALU_ILLEGAL;
         r_shift_amount <= '0;
         r_rd_addr      <= '0;
         r_rd_we        <= 1'b0;
         r_out_pc       <= RESET_PC;
      end else begin
         if (flush)          r_out_valid <= 1'b0;
         else if (w_accept)  r_out_valid <= 1'b1;
         else if (out_ready) r_out_valid <= 1'b0;

         if (w_accept) begin
            r_src1         <= w_src1;
            r_src2         <= w_src2;
            r_imm          <= w_imm;
            r_alu_cntrl    <= w_alu_cntrl;
            r_shift_amount <= in_instr[23:20];
            r_rd_addr      <= in_instr[11:7];
            r_rd_we        <= w_rd_we;
            r_out_pc       <= in_pc;
         end
      end
   end

   // Sticky trap flag when halting is enabled, otherwise a per-bundle tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_illegal <= 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      end else if (w_accept && w_illegal) begin
         r_illegal <= 1'b1;
`else
      end else if (w_accept) begin
         r_illegal <= w_illegal;
`endif
      end
   end

   assign in_ready     = w_in_ready;
   assign out_valid    = r_out_valid;
   assign src1         = r_src1;
   assign src2         = r_src2;
   assign imm_val      = r_imm;
   assign alu_cntrl    = r_alu_cntrl;
   assign shift_amount = r_shift_amount;
   assign rd_addr      = r_rd_addr;
   assign rd_we        = r_rd_we;
   assign out_pc       = r_out_pc;
   assign illegal      = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_decode_stage
// Brief    : Scoreboard bench for rv32i_decode_stage against a table-driven
//            match/mask instruction model.
// Revision : 1.0
// ============================================================================
module tb_rv32i_decode_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        flush;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] src1;
   logic [31:0] src2;
   logic [31:0] imm_val;
   logic [5:0]  alu_cntrl;
   logic [3:0]  shift_amount;
   logic [4:0]  rd_addr;
   logic        rd_we;
   logic [31:0] out_pc;
   logic        illegal;

   logic [31:0] rf [32];

   assign rs1_data = rf[rs1_addr];
   assign rs2_data = rf[rs2_addr];

   always #5 clk = ~clk;

   rv32i_decode_stage #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .src1(src1), .src2(src2), .imm_val(imm_val), .alu_cntrl(alu_cntrl),
      .shift_amount(shift_amount), .rd_addr(rd_addr), .rd_we(rd_we),
      .out_pc(out_pc), .illegal(illegal)
   );

   // fmt: 0 R, 1 I, 2 S, 3 B, 4 U (LUI), 5 SRAI
   typedef struct {
      logic [31:0] match;
      logic [31:0] mask;
      logic [5:0]  code;
      int          fmt;
   } ent_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] src1;
      logic [31:0] src2;
      logic [31:0] imm;
      logic        imm_chk;
      logic [5:0]  alu;
      logic [3:0]  shamt;
      logic [4:0]  rd;
      logic        rd_we;
      logic        ill;
   } exp_t;

   ent_t tbl[$];
   exp_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   halted   = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
   bit   trap_mode = 1'b1;
`else
   bit   trap_mode = 1'b0;
`endif

   task automatic add_ent(input logic [31:0] match, input logic [31:0] mask,
                          input logic [5:0] code, input int fmt);
      ent_t e;
      e.match = match; e.mask = mask; e.code = code; e.fmt = fmt;
      tbl.push_back(e);
   endtask

   task automatic build_table();
      add_ent(32'h0000_0033, 32'hFE00_707F, 6'h00, 0);
      add_ent(32'h4000_0033, 32'hFE00_707F, 6'h01, 0);
      add_ent(32'h0000_1033, 32'hFE00_707F, 6'h02, 0);
      add_ent(32'h0000_2033, 32'hFE00_707F, 6'h03, 0);
      add_ent(32'h0000_3033, 32'hFE00_707F, 6'h04, 0);
      add_ent(32'h0000_4033, 32'hFE00_707F, 6'h05, 0);
      add_ent(32'h0000_5033, 32'hFE00_707F, 6'h06, 0);
      add_ent(32'h4000_5033, 32'hFE00_707F, 6'h07, 0);
      add_ent(32'h0000_6033, 32'hFE00_707F, 6'h08, 0);
      add_ent(32'h0000_7033, 32'hFE00_707F, 6'h09, 0);
      add_ent(32'h0000_0013, 32'h0000_707F, 6'h0A, 1);
      add_ent(32'h0000_1013, 32'hFE00_707F, 6'h0B, 1);
      add_ent(32'h0000_2013, 32'h0000_707F, 6'h0C, 1);
      add_ent(32'h0000_3013, 32'h0000_707F, 6'h0D, 1);
      add_ent(32'h0000_4013, 32'h0000_707F, 6'h0E, 1);
      add_ent(32'h0000_5013, 32'hFE00_707F, 6'h0F, 1);
      add_ent(32'h4000_5013, 32'hFE00_707F, 6'h07, 5);
      add_ent(32'h0000_6013, 32'h0000_707F, 6'h10, 1);
      add_ent(32'h0000_7013, 32'h0000_707F, 6'h11, 1);
      add_ent(32'h0000_0037, 32'h0000_007F, 6'h12, 4);
      add_ent(32'h0000_0023, 32'h0000_707F, 6'h17, 2);
      add_ent(32'h0000_1023, 32'h0000_707F, 6'h18, 2);
      add_ent(32'h0000_2023, 32'h0000_707F, 6'h19, 2);
      add_ent(32'h0000_0063, 32'h0000_707F, 6'h1A, 3);
      add_ent(32'h0000_1063, 32'h0000_707F, 6'h1B, 3);
      add_ent(32'h0000_4063, 32'h0000_707F, 6'h1C, 3);
      add_ent(32'h0000_5063, 32'h0000_707F, 6'h1D, 3);
   endtask

   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
      exp_t e;
      int   hit = -1;
      for (int i = 0; i < tbl.size(); i++)
         if (hit < 0 && (ins & tbl[i].mask) == tbl[i].match) hit = i;
      e.pc      = pc;
      e.rd      = ins[11:7];
      e.shamt   = ins[23:20];
      e.src1    = (ins[19:15] == 5'd0) ? 32'd0 : rf[ins[19:15]];
      e.src2    = (ins[24:20] == 5'd0) ? 32'd0 : rf[ins[24:20]];
      e.imm     = 32'd0;
      e.imm_chk = 1'b0;
      e.alu     = 6'h3F;
      e.rd_we   = 1'b0;
      e.ill     = (hit < 0);
      if (hit >= 0) begin
         e.alu     = tbl[hit].code;
         e.imm_chk = (tbl[hit].fmt != 0);
         case (tbl[hit].fmt)
            0: e.rd_we = 1'b1;
            1: begin e.rd_we = 1'b1; e.imm = {{20{ins[31]}}, ins[31:20]}; end
            5: begin
               e.rd_we = 1'b1;
               e.imm   = {{20{ins[31]}}, ins[31:20]};
               e.src2  = {27'd0, ins[24:20]};
            end
            2: e.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            3: e.imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
            default: begin e.rd_we = 1'b1; e.imm = {12'd0, ins[31:12]}; end
         endcase
         if (e.rd == 5'd0) e.rd_we = 1'b0;
      end
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor/scoreboard: compares the held bundle every cycle it is presented.
   always @(negedge clk) begin
      exp_t e;
      logic exp_rdy;
      if (rst) begin
         q.delete();
         halted = 1'b0;
      end else begin
         exp_rdy = !halted && (q.size() == 0 || out_ready);
         chk("in_ready", in_ready, exp_rdy);
         chk("rs1_addr", rs1_addr, in_instr[19:15]);
         chk("out_valid", out_valid, q.size() != 0);
         if (out_valid && q.size() != 0) begin
            e = q[0];
            chk("alu_cntrl", alu_cntrl, e.alu);
            chk("src1", src1, e.src1);
            chk("src2", src2, e.src2);
            if (e.imm_chk) chk("imm_val", imm_val, e.imm);
            chk("shift_amount", shift_amount, e.shamt);
            chk("rd_addr", rd_addr, e.rd);
            chk("rd_we", rd_we, e.rd_we);
            chk("out_pc", out_pc, e.pc);
            chk("illegal", illegal, e.ill);
            if (out_ready || flush) void'(q.pop_front());
         end
         if (in_valid && exp_rdy && !flush) begin
            e = model(in_instr, in_pc);
            q.push_back(e);
            if (trap_mode && e.ill) halted = 1'b1;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl);
      in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
      step();
   endtask

   function automatic logic [31:0] rand_instr(input bit allow_illegal);
      int k;
      if (allow_illegal && $urandom_range(0, 7) == 0) return $urandom;
      k = $urandom_range(0, tbl.size() - 1);
      return ($urandom & ~tbl[k].mask) | tbl[k].match;
   endfunction

   initial begin
      build_table();
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      rf[0] = 32'hDEAD_BEEF;
      rf[1] = 32'd5;
      rf[2] = 32'd7;
      rst = 1'b1;
      in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0; out_ready = 1'b0; flush = 1'b0;
      repeat (3) step();

      chk("rst_out_valid", out_valid, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_src1", src1, 0);
      chk("rst_src2", src2, 0);
      chk("rst_imm", imm_val, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_rd_we", rd_we, 0);
      chk("rst_shamt", shift_amount, 0);
      chk("rst_alu", alu_cntrl, 32'h3F);
      chk("rst_out_pc", out_pc, RESET_PC);
      rst = 1'b0;
      step();
      chk("rdy_after_rst", in_ready, 1);

      // add x3,x1,x2
      drive(1, 32'h0020_81B3, 32'h100, 1, 0);
      in_valid = 1'b0;
      chk("add_valid", out_valid, 1);
      chk("add_alu", alu_cntrl, 32'h00);
      chk("add_src1", src1, 5);
      chk("add_src2", src2, 7);
      chk("add_rd", rd_addr, 3);
      chk("add_rd_we", rd_we, 1);
      // addi x1,x0,-1 with a nonzero value on the x0 read port
      drive(1, 32'hFFF0_0093, 32'h104, 1, 0);
      chk("addi_alu", alu_cntrl, 32'h0A);
      chk("addi_imm", imm_val, 32'hFFFF_FFFF);
      chk("addi_src1", src1, 0);
      drive(1, 32'h0020_8463, 32'h108, 1, 0);
      chk("beq_alu", alu_cntrl, 32'h1A);
      chk("beq_imm", imm_val, 8);
      chk("beq_rd_we", rd_we, 0);
      drive(1, 32'h0020_A223, 32'h10C, 1, 0);
      chk("sw_alu", alu_cntrl, 32'h19);
      chk("sw_imm", imm_val, 4);

      // Back-pressure with a queued instruction
      drive(1, 32'h4020_81B3, 32'h200, 1, 0);
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h0030_C233, 32'h204, 0, 0);
         chk("stall_in_ready", in_ready, 0);
         chk("stall_pc", out_pc, 32'h200);
      end
      drive(1, 32'h0030_C233, 32'h204, 1, 0);
      chk("release_pc", out_pc, 32'h204);
      drive(0, 32'h0, 32'h0, 1, 0);
      chk("drain_valid", out_valid, 0);

      // Flush during a stall kills the held and the presented instruction
      drive(1, 32'h0020_81B3, 32'h300, 1, 0);
      drive(1, 32'h0010_0113, 32'h304, 0, 1);
      chk("flush_valid", out_valid, 0);
      drive(0, 32'h0, 32'h0, 1, 0);
      chk("flush_gone", out_valid, 0);

      // Illegal load
      drive(1, 32'h0000_0003, 32'h400, 1, 0);
      chk("ill_alu", alu_cntrl, 32'h3F);
      chk("ill_rd_we", rd_we, 0);
      chk("ill_flag", illegal, 1);
      if (trap_mode) begin
         for (int i = 0; i < 3; i++) begin
            drive(1, 32'h0020_81B3, 32'h404, 1, i == 1);
            chk("halt_in_ready", in_ready, 0);
            chk("halt_sticky", illegal, 1);
         end
         rst = 1'b1;
         drive(0, 32'h0, 32'h0, 1, 0);
         rst = 1'b0;
         step();
         chk("unhalt_ready", in_ready, 1);
         chk("unhalt_illegal", illegal, 0);
      end else begin
         drive(1, 32'h0020_81B3, 32'h404, 1, 0);
         chk("post_ill_valid", out_valid, 1);
         chk("post_ill_alu", alu_cntrl, 32'h00);
         chk("post_ill_flag", illegal, 0);
      end

      // Reset while stalled discards the held bundle
      drive(1, 32'h0020_81B3, 32'h500, 1, 0);
      drive(0, 32'h0, 32'h0, 0, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_stall_valid", out_valid, 0);
      chk("rst_stall_pc", out_pc, RESET_PC);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 499) == 0);
         drive($urandom_range(0, 3) != 0, rand_instr(!trap_mode),
               {$urandom_range(0, 32'h0FFF_FFFF), 2'b00},
               $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
      end
      rst = 1'b0;
      drive(0, 32'h0, 32'h0, 1, 0);
      step();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
